// File: rtl/btb_pkg.sv
// Shared types for the BTB write side.
// Index width helper, update record and FSM encoding.
package btb_pkg;

  function automatic int idx_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] target;
    logic        taken;
  } btb_upd_t;

  typedef enum logic [1:0] {
    IDLE,
    PROBE,
    WRITE
  } btb_upd_state_e;

endpackage

// File: rtl/plru_tree.sv
// Tree pseudo-LRU state for a fully associative array.
// Node bit 0 steers the victim search into the left subtree.
module plru_tree
  import btb_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int IW    = idx_w(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          touch_a_en,
  input  logic [IW-1:0] touch_a_idx,
  input  logic          touch_b_en,
  input  logic [IW-1:0] touch_b_idx,
  output logic [IW-1:0] victim
);

  logic [DEPTH-2:0] bits_q;
  logic [DEPTH-2:0] bits_d;

  // Heap-ordered nodes: node n lives at bit n-1.
  function automatic logic [DEPTH-2:0] touch(
    input logic [DEPTH-2:0] b,
    input logic [IW-1:0]    idx
  );
    logic [DEPTH-2:0] r;
    int               node;
    r    = b;
    node = 1;
    for (int l = 0; l < IW; l++) begin
      r[node-1] = ~idx[IW-1-l];
      node      = 2 * node + int'(idx[IW-1-l]);
    end
    return r;
  endfunction

  always_comb begin
    bits_d = bits_q;
    if (touch_a_en) bits_d = touch(bits_d, touch_a_idx);
    if (touch_b_en) bits_d = touch(bits_d, touch_b_idx);
    if (clear)      bits_d = '0;
  end

  always_comb begin
    int node;
    node = 1;
    for (int l = 0; l < IW; l++) begin
      node = 2 * node + int'(bits_q[node-1]);
    end
    victim = IW'(node - DEPTH);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bits_q <= '0;
    else        bits_q <= bits_d;
  end

endmodule

// File: rtl/btb_update_unit.sv
// BTB write side: queues resolved branches, probes tags,
// then issues one allocate/retarget/invalidate write.
module btb_update_unit
  import btb_pkg::*;
#(
  parameter  int BTB_DEPTH  = 8,
  parameter  int FIFO_DEPTH = 4,
  localparam int IDX_W      = idx_w(BTB_DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             upd_valid,
  output logic             upd_ready,
  input  logic [31:0]      upd_pc,
  input  logic [31:0]      upd_target,
  input  logic             upd_taken,
  input  logic             lkp_hit,
  input  logic [IDX_W-1:0] lkp_idx,
  output logic             probe_valid,
  output logic [31:0]      probe_pc,
  input  logic             probe_hit,
  input  logic [IDX_W-1:0] probe_idx,
  output logic             wr_en,
  output logic [IDX_W-1:0] wr_idx,
  output logic             wr_valid,
  output logic [31:0]      wr_pc,
  output logic [31:0]      wr_target,
  input  logic             flush,
  output logic             flush_out
);

  localparam int PTR_W = idx_w(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(FIFO_DEPTH);

  btb_upd_state_e   state_q, state_d;
  btb_upd_t         fifo_q [FIFO_DEPTH];
  btb_upd_t         work_q;
  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic [BTB_DEPTH-1:0] valid_q;

  logic             push, pop;
  logic [IDX_W-1:0] victim, free_idx, sel_idx;
  logic             free_found, do_write, sel_valid;
  logic [IDX_W-1:0] wr_idx_q;
  logic             wr_valid_q;
  logic [31:0]      wr_pc_q, wr_target_q;
  logic             flush_q;

  assign upd_ready = (cnt_q != FULL) && !flush;
  assign push      = upd_valid && upd_ready;
  assign pop       = (state_q == IDLE) && (cnt_q != '0) && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
    end else if (flush) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr_q] <= '{upd_pc, upd_target, upd_taken};
        wr_ptr_q         <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Scan downward so the lowest invalid index wins.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = BTB_DEPTH - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

  always_comb begin
    do_write  = 1'b0;
    sel_idx   = victim;
    sel_valid = 1'b0;
    unique case (1'b1)
      work_q.taken && probe_hit: begin
        do_write  = 1'b1;
        sel_idx   = probe_idx;
        sel_valid = 1'b1;
      end
      work_q.taken && !probe_hit: begin
        do_write  = 1'b1;
        sel_idx   = free_found ? free_idx : victim;
        sel_valid = 1'b1;
      end
      !work_q.taken && probe_hit: begin
        do_write  = 1'b1;
        sel_idx   = probe_idx;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (pop) state_d = PROBE;
      PROBE:   state_d = do_write ? WRITE : IDLE;
      WRITE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  assign probe_valid = (state_q == PROBE);
  assign probe_pc    = probe_valid ? work_q.pc : '0;
  assign wr_en       = (state_q == WRITE) && !flush;
  assign wr_idx      = wr_idx_q;
  assign wr_valid    = wr_valid_q;
  assign wr_pc       = wr_pc_q;
  assign wr_target   = wr_target_q;
  assign flush_out   = flush_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      work_q      <= '0;
      wr_idx_q    <= '0;
      wr_valid_q  <= 1'b0;
      wr_pc_q     <= '0;
      wr_target_q <= '0;
      valid_q     <= '0;
      flush_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      flush_q <= flush;
      if (flush) begin
        work_q  <= '0;
        valid_q <= '0;
      end else begin
        if (pop) work_q <= fifo_q[rd_ptr_q];
        if (probe_valid && do_write) begin
          wr_idx_q    <= sel_idx;
          wr_valid_q  <= sel_valid;
          wr_pc_q     <= work_q.pc;
          wr_target_q <= work_q.target;
        end
        if (wr_en) valid_q[wr_idx_q] <= wr_valid_q;
      end
    end
  end

  plru_tree #(.DEPTH(BTB_DEPTH)) u_plru (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (flush),
    .touch_a_en  (lkp_hit),
    .touch_a_idx (lkp_idx),
    .touch_b_en  (wr_en && wr_valid_q),
    .touch_b_idx (wr_idx_q),
    .victim      (victim)
  );

endmodule

// File: tb/tb_btb_update_unit.sv
// Directed bench for btb_update_unit with a small tag-array
// model answering probes from the writes it observes.
module tb_btb_update_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        upd_valid, upd_taken, lkp_hit, flush;
  logic        upd_ready, probe_valid, probe_hit;
  logic [31:0] upd_pc, upd_target, probe_pc;
  logic [2:0]  lkp_idx, probe_idx, wr_idx;
  logic        wr_en, wr_valid, flush_out;
  logic [31:0] wr_pc, wr_target;

  btb_update_unit #(.BTB_DEPTH(8), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .upd_valid(upd_valid), .upd_ready(upd_ready),
    .upd_pc(upd_pc), .upd_target(upd_target),
    .upd_taken(upd_taken),
    .lkp_hit(lkp_hit), .lkp_idx(lkp_idx),
    .probe_valid(probe_valid), .probe_pc(probe_pc),
    .probe_hit(probe_hit), .probe_idx(probe_idx),
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_valid(wr_valid),
    .wr_pc(wr_pc), .wr_target(wr_target),
    .flush(flush), .flush_out(flush_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] target;
    logic        taken;
    int          lkp_n;
    logic [2:0]  lkp [8];
    logic        exp_wr;
    logic [2:0]  exp_idx;
    logic        exp_valid;
  } vec_t;

  typedef struct {
    int          cyc;
    logic [2:0]  idx;
    logic        v;
    logic [31:0] pc;
    logic [31:0] tgt;
  } wl_t;

  int   n_app = 0;
  int   n_err = 0;
  int   cyc = 0;
  wl_t  wq[$];
  int   pq[$];
  int   fq[$];
  vec_t vt[15];

  logic [31:0] m_pc [8];
  logic        m_v  [8];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    wl_t e;
    if (wr_en) begin
      e.cyc = cyc + 1;
      e.idx = wr_idx;
      e.v   = wr_valid;
      e.pc  = wr_pc;
      e.tgt = wr_target;
      wq.push_back(e);
    end
    if (probe_valid) pq.push_back(cyc + 1);
    if (flush_out)   fq.push_back(cyc + 1);
  end

  // Tag storage the DUT writes into.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) begin
        m_v[i]  <= 1'b0;
        m_pc[i] <= '0;
      end
    end else if (flush_out) begin
      for (int i = 0; i < 8; i++) m_v[i] <= 1'b0;
    end else if (wr_en) begin
      m_pc[wr_idx] <= wr_pc;
      m_v[wr_idx]  <= wr_valid;
    end
  end

  always_comb begin
    probe_hit = 1'b0;
    probe_idx = '0;
    for (int i = 0; i < 8; i++) begin
      if (m_v[i] && m_pc[i] == probe_pc) begin
        probe_hit = 1'b1;
        probe_idx = 3'(i);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_app++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mkv(input logic [31:0] pc,
                               input logic [31:0] tgt,
                               input logic tk, input logic ew,
                               input logic [2:0] ei,
                               input logic ev);
    vec_t v;
    v.pc = pc; v.target = tgt; v.taken = tk;
    v.lkp_n = 0;
    for (int i = 0; i < 8; i++) v.lkp[i] = '0;
    v.exp_wr = ew; v.exp_idx = ei; v.exp_valid = ev;
    return v;
  endfunction

  task automatic run_vec(input vec_t v, input int n);
    int t;
    for (int k = 0; k < v.lkp_n; k++) begin
      @(negedge clk);
      lkp_hit = 1'b1;
      lkp_idx = v.lkp[k];
    end
    @(negedge clk);
    lkp_hit = 1'b0;
    wq.delete();
    pq.delete();
    upd_valid = 1'b1;
    upd_pc = v.pc; upd_target = v.target; upd_taken = v.taken;
    @(posedge clk); #1;
    t = cyc;
    upd_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk($sformatf("v%0d_probes", n), pq.size(), 1);
    chk($sformatf("v%0d_probe_cyc", n),
        pq.size() > 0 ? pq[0] : -1, t + 2);
    if (v.exp_wr) begin
      chk($sformatf("v%0d_writes", n), wq.size(), 1);
      if (wq.size() > 0) begin
        chk($sformatf("v%0d_wr_cyc", n), wq[0].cyc, t + 3);
        chk($sformatf("v%0d_wr_idx", n), wq[0].idx, v.exp_idx);
        chk($sformatf("v%0d_wr_valid", n), wq[0].v, v.exp_valid);
        chk($sformatf("v%0d_wr_pc", n), wq[0].pc, v.pc);
        chk($sformatf("v%0d_wr_tgt", n), wq[0].tgt, v.target);
      end
    end else begin
      chk($sformatf("v%0d_no_write", n), wq.size(), 0);
    end
  endtask

  logic [31:0] bpc [7];
  logic [2:0]  bix [7];
  logic [8:0]  rs;
  logic        r;
  int          k, t0, t;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 8; i++)
      vt[i] = mkv(32'h1000 + 32'(i * 256), 32'h2000 + 32'(i * 256),
                  1'b1, 1'b1, 3'(i), 1'b1);
    // Hit order leaves the tree pointing at entry 7.
    vt[8] = mkv(32'h9000, 32'h9100, 1'b1, 1'b1, 3'd7, 1'b1);
    vt[8].lkp_n = 7;
    vt[8].lkp = '{3'd6, 3'd4, 3'd5, 3'd0, 3'd1, 3'd2, 3'd3, 3'd0};
    vt[9] = mkv(32'hA000, 32'hA100, 1'b1, 1'b1, 3'd0, 1'b1);
    vt[9].lkp_n = 1;
    vt[9].lkp[0] = 3'd7;
    vt[10] = mkv(32'h1300, 32'h3000, 1'b1, 1'b1, 3'd3, 1'b1);
    vt[11] = mkv(32'h1300, 32'h3000, 1'b0, 1'b1, 3'd3, 1'b0);
    vt[12] = mkv(32'hB000, 32'hB100, 1'b1, 1'b1, 3'd3, 1'b1);
    vt[13] = mkv(32'hC000, 32'hC100, 1'b1, 1'b1, 3'd4, 1'b1);
    vt[14] = mkv(32'hD000, 32'hD100, 1'b0, 1'b0, 3'd0, 1'b0);
    bpc = '{32'h1100, 32'h1200, 32'h1500, 32'h1600,
            32'h9000, 32'hA000, 32'hB000};
    bix = '{3'd1, 3'd2, 3'd5, 3'd6, 3'd7, 3'd0, 3'd3};

    rst_n = 1'b0;
    upd_valid = 1'b0; upd_pc = '0; upd_target = '0;
    upd_taken = 1'b0; lkp_hit = 1'b0; lkp_idx = '0;
    flush = 1'b0;
    #1;
    chk("rst_upd_ready", upd_ready, 1);
    chk("rst_probe_valid", probe_valid, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_valid", wr_valid, 0);
    chk("rst_wr_idx", wr_idx, 0);
    chk("rst_wr_pc", wr_pc, 0);
    chk("rst_wr_target", wr_target, 0);
    chk("rst_flush_out", flush_out, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 15; i++) run_vec(vt[i], i);

    // Back-to-back retarget hits fill the queue.
    wq.delete();
    k = 0; t0 = 0; rs = '0;
    @(negedge clk);
    upd_valid = 1'b1; upd_taken = 1'b1;
    upd_pc = bpc[0]; upd_target = 32'h5000;
    for (int s = 0; s < 20 && k < 7; s++) begin
      r = upd_ready;
      if (s < 9) rs[s] = r;
      @(posedge clk); #1;
      if (s == 0) t0 = cyc;
      if (r) begin
        k++;
        if (k < 7) begin
          upd_pc = bpc[k];
          upd_target = 32'h5000 + 32'(k * 16);
        end else upd_valid = 1'b0;
      end
      @(negedge clk);
    end
    upd_valid = 1'b0;
    chk("burst_pushes", k, 7);
    chk("burst_ready_seq", {23'd0, rs}, 32'h13F);
    repeat (30) @(posedge clk);
    #1;
    chk("burst_writes", wq.size(), 7);
    for (int j = 0; j < 7; j++) begin
      if (j < wq.size()) begin
        chk($sformatf("burst%0d_cyc", j), wq[j].cyc, t0 + 3 + 3 * j);
        chk($sformatf("burst%0d_idx", j), wq[j].idx, bix[j]);
        chk($sformatf("burst%0d_pc", j), wq[j].pc, bpc[j]);
        chk($sformatf("burst%0d_tgt", j), wq[j].tgt,
            32'h5000 + 32'(j * 16));
      end
    end

    // Flush while the second record is probing, two still queued.
    wq.delete(); pq.delete(); fq.delete();
    @(negedge clk);
    upd_valid = 1'b1; upd_taken = 1'b1;
    upd_pc = 32'h1100; upd_target = 32'h7000;
    t = 0;
    for (int j = 0; j < 4; j++) begin
      @(posedge clk); #1;
      if (j == 0) t = cyc;
      upd_pc = bpc[j + 1];
      if (j == 3) upd_valid = 1'b0;
    end
    @(posedge clk); #1;
    flush = 1'b1;
    #1;
    chk("flush_probe_active", probe_valid, 1);
    chk("flush_ready_low", upd_ready, 0);
    chk("flush_wr_en_low", wr_en, 0);
    @(posedge clk); #1;
    flush = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    chk("flush_writes", wq.size(), 1);
    if (wq.size() > 0) begin
      chk("flush_pre_cyc", wq[0].cyc, t + 3);
      chk("flush_pre_idx", wq[0].idx, 1);
    end
    chk("flush_probes", pq.size(), 2);
    chk("flush_out_pulses", fq.size(), 1);
    chk("flush_out_cyc", fq.size() > 0 ? fq[0] : -1, t + 6);
    run_vec(mkv(32'hE000, 32'hE100, 1'b1, 1'b1, 3'd0, 1'b1), 15);

    // Asynchronous reset during PROBE aborts the write.
    wq.delete();
    @(negedge clk);
    upd_valid = 1'b1; upd_taken = 1'b1;
    upd_pc = 32'hF000; upd_target = 32'hF100;
    @(posedge clk); #1;
    upd_valid = 1'b0;
    @(posedge clk); #2;
    chk("arst_in_probe", probe_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("arst_probe_valid", probe_valid, 0);
    chk("arst_wr_en", wr_en, 0);
    chk("arst_upd_ready", upd_ready, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    chk("arst_no_write", wq.size(), 0);
    chk("arst_idle", probe_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_app, n_err);
    $finish;
  end

endmodule
